// File: rtl/entrada_digito.sv
// Digit-entry front end: synchronises and debounces the push-button and strobes the latched switch digit once per clean press.
// Optional macro DIGIT_RANGE_CHECK_EN rejects digits above 9 with an `invalido` strobe instead of `insere`.
module entrada_digito #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao,
    input  logic [3:0] chaves,
    output logic       insere,
    output logic [3:0] numero,
    output logic       invalido
);

    typedef enum logic [1:0] {
        OCIOSO,
        CONF_PRESS,
        PRESSIONADO,
        CONF_SOLTA
    } estado_t;

    // cnt holds the stable samples already seen, so the edge carrying the
    // DEBOUNCE_CYCLES-th consecutive sample is the one that accepts
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             b_s1, b_s;
    logic [3:0]       c_s1, c_s;
    estado_t          estado, estado_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             aceita;
    logic             valido;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            b_s1 <= 1'b0;
            b_s  <= 1'b0;
            c_s1 <= '0;
            c_s  <= '0;
        end else begin
            b_s1 <= botao;
            b_s  <= b_s1;
            c_s1 <= chaves;
            c_s  <= c_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= PRESSIONADO;
            cnt    <= '0;
        end else begin
            estado <= estado_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        aceita   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (b_s) begin
                    if (ULTIMO == '0) begin
                        aceita   = 1'b1;
                        estado_n = PRESSIONADO;
                        cnt_n    = '0;
                    end else begin
                        estado_n = CONF_PRESS;
                        cnt_n    = CNT_W'(1);
                    end
                end
            end
            CONF_PRESS: begin
                if (!b_s) begin
                    estado_n = OCIOSO;
                    cnt_n    = '0;
                end else if (cnt >= ULTIMO) begin
                    aceita   = 1'b1;
                    estado_n = PRESSIONADO;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            PRESSIONADO: begin
                if (!b_s) begin
                    if (ULTIMO == '0) begin
                        estado_n = OCIOSO;
                        cnt_n    = '0;
                    end else begin
                        estado_n = CONF_SOLTA;
                        cnt_n    = CNT_W'(1);
                    end
                end
            end
            CONF_SOLTA: begin
                if (b_s) begin
                    estado_n = PRESSIONADO;
                    cnt_n    = '0;
                end else if (cnt >= ULTIMO) begin
                    estado_n = OCIOSO;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                estado_n = OCIOSO;
                cnt_n    = '0;
            end
        endcase
    end

`ifdef DIGIT_RANGE_CHECK_EN
    assign valido = (c_s <= 4'd9);

    always_ff @(posedge clk) begin
        if (reset) invalido <= 1'b0;
        else       invalido <= aceita & ~valido;
    end
`else
    assign valido   = 1'b1;
    assign invalido = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            insere <= 1'b0;
            numero <= '0;
        end else begin
            insere <= aceita & valido;
            if (aceita & valido) numero <= c_s;
        end
    end

endmodule

// File: tb/tb_entrada_digito.sv
// Randomised scoreboard bench for entrada_digito; a run-length debounce model predicts each strobe's cycle and digit.
module tb_entrada_digito;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       botao;
    logic [3:0] chaves;
    logic       insere;
    logic [3:0] numero;
    logic       invalido;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        bit         inv;
        logic [3:0] num;
    } exp_t;
    exp_t q[$];

    logic [3:0] model_last = 4'd0;

    entrada_digito #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
        .clk     (clk),
        .reset   (reset),
        .botao   (botao),
        .chaves  (chaves),
        .insere  (insere),
        .numero  (numero),
        .invalido(invalido)
    );

    always #5 clk = ~clk;

    // Reference: b_s/c_s are the raw inputs two edges late; the debounced level
    // flips after D consecutive samples that disagree with it.
    initial begin
        logic       m1, m2, bs, stable;
        logic [3:0] mc1, mc2, cs;
        int         run;
        m1 = 0; m2 = 0; mc1 = 0; mc2 = 0; stable = 1; run = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset === 1'b1) begin
                m1 = 0; m2 = 0; mc1 = 0; mc2 = 0;
                stable = 1; run = 0; model_last = 4'd0;
            end else begin
                bs = m2; cs = mc2;
                m2 = m1; mc2 = mc1;
                m1 = botao; mc1 = chaves;
                if (bs != stable) begin
                    run++;
                    if (run == D) begin
                        stable = bs;
                        run = 0;
                        if (stable) begin
`ifdef DIGIT_RANGE_CHECK_EN
                            if (cs > 4'd9) q.push_back('{cyc, 1'b1, model_last});
                            else begin
                                model_last = cs;
                                q.push_back('{cyc, 1'b0, cs});
                            end
`else
                            model_last = cs;
                            q.push_back('{cyc, 1'b0, cs});
`endif
                        end
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT strobes or one falls due.
    initial begin
        exp_t e;
        bit   due;
        forever begin
            @(negedge clk);
            if (cyc > 2) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++; errors++;
                    $display("FAIL missed_strobe: expected at cycle %0d digit %0d inv %0d, DUT did not strobe", e.cyc, e.num, e.inv);
                end
                due = (q.size() > 0 && q[0].cyc == cyc);
                if (insere === 1'b1 || invalido === 1'b1 || due) begin
                    checks++;
                    if (!due) begin
                        errors++;
                        $display("FAIL unexpected_strobe: cycle %0d insere=%b invalido=%b numero=%0d, none required", cyc, insere, invalido, numero);
                    end else begin
                        e = q.pop_front();
                        if (insere !== !e.inv || invalido !== e.inv || numero !== e.num) begin
                            errors++;
                            $display("FAIL strobe: cycle %0d got insere=%b invalido=%b numero=%0d, required insere=%b invalido=%b numero=%0d",
                                     cyc, insere, invalido, numero, !e.inv, e.inv, e.num);
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        chaves = d;
        botao  = 1'b1;
        idle(hold);
        botao  = 1'b0;
        idle(2 * D + 4);
    endtask

    initial begin
        logic [3:0] seq[6] = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};

        // Button held before and through reset
        botao = 1'b1; chaves = 4'd0; reset = 1'b1;
        idle(3);
        checks++;
        if (insere !== 1'b0 || numero !== 4'd0 || invalido !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: insere=%b numero=%0d invalido=%b, required 0 0 0", insere, numero, invalido);
        end
        reset = 1'b0;
        idle(20);
        botao = 1'b0;
        idle(10);
        press(4'd5, 10);

        press(4'd9, 8);

        // Bounces of 1, 2, 3 cycles high
        chaves = 4'd7;
        for (int w = 1; w <= 3; w++) begin
            botao = 1'b1; idle(w);
            botao = 1'b0; idle(1);
        end
        idle(10);

        foreach (seq[i]) press(seq[i], $urandom_range(D + 1, 12));

        press(4'd3, 50);

        // Reset while confirming a press
        chaves = 4'd6; botao = 1'b1;
        idle(3);
        reset = 1'b1; botao = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(20);

        press(4'd12, 8);

        // Random button activity including glitches and long holds
        for (int i = 0; i < 80; i++) begin
            botao  = 1'($urandom_range(0, 1));
            chaves = 4'($urandom_range(0, 15));
            idle($urandom_range(1, 9));
        end
        botao = 1'b0;
        idle(2 * D + 10);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_queue: %0d expectations left, required 0", q.size());
        end
        checks++;
        if (numero !== model_last) begin
            errors++;
            $display("FAIL final_numero: got %0d, required %0d", numero, model_last);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
